// File: rtl/cim_pkg.sv
// Shared types and helpers for the CiM dot-product sequencer and its ALU.
package cim_pkg;

    localparam int ALU_XNOR      = 0;
    localparam int ALU_MUL       = 1;
    localparam int POP_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } dot_state_e;

    // Counts set bits among the lowest 'width' bits; callers zero-extend into the fixed-width argument.
    function automatic int unsigned popcount(input logic [POP_MAX_WIDTH-1:0] value, input int width);
        int unsigned count;
        count = 0;
        for (int i = 0; i < POP_MAX_WIDTH; i++) begin
            if (i < width && value[i]) begin
                count++;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/cim_dot_ctrl_alu.sv
// Element-wise ALU for the CiM array: XNOR for binary networks, or a truncated multiply.
module alu
    import cim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_KIND   = ALU_XNOR
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    // Low DATA_WIDTH bits of the product are identical for signed and unsigned operands.
    always_comb begin
        result = '0;
        if (ALU_KIND == ALU_XNOR) begin
            result = ~(a ^ b);
        end else if (ALU_KIND == ALU_MUL) begin
            result = a * b;
        end
    end

endmodule

// File: rtl/cim_dot_ctrl.sv
// Streams N operand pairs through one ALU and reduces the element results into a single accumulator beat.
module cim_dot_ctrl
    import cim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_KIND   = 0,
    parameter int LEN_WIDTH  = 8,
    parameter int ACC_WIDTH  = 48
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [ACC_WIDTH-1:0]  res_data_o,
    output logic                  busy_o
);

    dot_state_e            state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [ACC_WIDTH-1:0]  contrib;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    alu #(
        .DATA_WIDTH(DATA_WIDTH),
        .ALU_KIND  (ALU_KIND)
    ) u_alu (
        .a     (op_a_i),
        .b     (op_b_i),
        .result(alu_result)
    );

    // Per-element contribution of the staged ALU result; wraps modulo 2^ACC_WIDTH.
    always_comb begin
        contrib = '0;
        if (ALU_KIND == ALU_XNOR) begin
            contrib = ACC_WIDTH'(popcount(POP_MAX_WIDTH'(s1_data), DATA_WIDTH));
        end else if (ALU_KIND == ALU_MUL) begin
            contrib = ACC_WIDTH'($signed(s1_data));
        end
        acc_next = s1_valid ? acc_q + contrib : acc_q;
    end

    assign res_data_o = acc_q;

    // The stage register drains into the accumulator every cycle, so DRAIN exists only to absorb the last element.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            s1_data     <= '0;
            s1_valid    <= 1'b0;
            cmd_ready_o <= 1'b1;
            op_ready_o  <= 1'b0;
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            acc_q    <= acc_next;
            s1_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        len_q       <= cmd_len_i;
                        cnt_q       <= '0;
                        acc_q       <= '0;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (cmd_len_i == '0) begin
                            state_q     <= DONE;
                            res_valid_o <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            op_ready_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (op_valid_i) begin
                        cnt_q    <= cnt_q + LEN_WIDTH'(1);
                        s1_data  <= alu_result;
                        s1_valid <= 1'b1;
                        if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                            state_q    <= DRAIN;
                            op_ready_o <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state_q     <= DONE;
                    res_valid_o <= 1'b1;
                end
                DONE: begin
                    if (res_ready_i) begin
                        state_q     <= IDLE;
                        res_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
